// File: rtl/apb_arb_pkg.sv
// Shared types and defaults for the APB master arbiter.
package apb_arb_pkg;

    localparam int unsigned APB_ARB_ADDR_W          = 32;
    localparam int unsigned APB_ARB_DATA_W          = 32;
    localparam int unsigned APB_ARB_TIMEOUT_DEFAULT = 256;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } arb_state_e;

    // One requester command at the default bus widths.
    typedef struct packed {
        logic                      write;
        logic [APB_ARB_ADDR_W-1:0] addr;
        logic [APB_ARB_DATA_W-1:0] wdata;
    } apb_req_t;

endpackage

// File: rtl/apb_master_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first set request
// found searching upward (with wrap) from i_ptr.
module rr_arbiter #(
    parameter int unsigned N  = 2,
    parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    input  logic          i_en,
    output logic [N-1:0]  o_grant
);

    // Scan offsets 0..N-1 from the pointer; the first requesting slot wins.
    always_comb begin
        logic w_found;
        w_found = 1'b0;
        o_grant = '0;
        for (int unsigned k = 0; k < N; k++) begin
            for (int unsigned j = 0; j < N; j++) begin
                if (i_en && !w_found && i_req[j] &&
                    ((32'(i_ptr) + k == j) || (32'(i_ptr) + k == j + N))) begin
                    o_grant[j] = 1'b1;
                    w_found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// APB master shared between NUM_REQ requesters with round-robin arbitration.
// Optional ACCESS-phase timeout abort: define APB_ARB_TIMEOUT_EN.
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned APB_ADDR_WIDTH = APB_ARB_ADDR_W,
    parameter int unsigned APB_DATA_WIDTH = APB_ARB_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = APB_ARB_TIMEOUT_DEFAULT
) (
    input  logic                                pclk,
    input  logic                                presetn,
    input  logic [NUM_REQ-1:0]                  req_valid,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic [NUM_REQ-1:0]                  req_write,
    input  logic [NUM_REQ*APB_ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*APB_DATA_WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]                  rsp_valid,
    output logic [APB_DATA_WIDTH-1:0]           rsp_rdata,
    output logic                                rsp_err,
    output logic [APB_ADDR_WIDTH-1:0]           paddr,
    output logic                                psel,
    output logic                                penable,
    output logic                                pwrite,
    output logic [APB_DATA_WIDTH-1:0]           pwdata,
    input  logic [APB_DATA_WIDTH-1:0]           prdata,
    input  logic                                pready,
    input  logic                                pslverr
);

    localparam int unsigned PW = $clog2(NUM_REQ);

    arb_state_e                r_state;
    arb_state_e                w_state_nxt;
    logic [PW-1:0]             r_last_grant;
    logic [PW-1:0]             w_ptr;
    logic [NUM_REQ-1:0]        w_grant;
    logic [PW-1:0]             w_sel_idx;
    logic                      w_sel_write;
    logic [APB_ADDR_WIDTH-1:0] w_sel_addr;
    logic [APB_DATA_WIDTH-1:0] w_sel_wdata;
    logic                      w_timeout;

    logic [APB_ADDR_WIDTH-1:0] r_paddr;
    logic [APB_DATA_WIDTH-1:0] r_pwdata;
    logic                      r_pwrite;
    logic                      r_psel;
    logic                      r_penable;
    logic [NUM_REQ-1:0]        r_rsp_valid;
    logic [APB_DATA_WIDTH-1:0] r_rsp_rdata;
    logic                      r_rsp_err;

    // Search starts one past the last winner.
    assign w_ptr = (r_last_grant == PW'(NUM_REQ - 1)) ? '0 : r_last_grant + 1'b1;

    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_rr_arbiter (
        .i_req   (req_valid),
        .i_ptr   (w_ptr),
        .i_en    (r_state == IDLE),
        .o_grant (w_grant)
    );

    // Pick the granted requester's command out of the packed buses.
    always_comb begin
        w_sel_idx   = '0;
        w_sel_write = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_idx   = PW'(i);
                w_sel_write = req_write[i];
                w_sel_addr  = req_addr[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
                w_sel_wdata = req_wdata[i*APB_DATA_WIDTH +: APB_DATA_WIDTH];
            end
        end
    end

`ifdef APB_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_to_cnt;

    // Count stalled ACCESS cycles; cleared while in SETUP so it starts at 0.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_to_cnt <= '0;
        end else if (r_state == SETUP) begin
            r_to_cnt <= '0;
        end else if (r_state == ACCESS && !pready) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // Abort at the end of the TIMEOUT_CYCLES-th stalled cycle; pready wins.
    assign w_timeout = (r_state == ACCESS) && !pready && (r_to_cnt == TO_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and the combinational accept pulse.
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        case (r_state)
            IDLE: begin
                if (|w_grant) begin
                    req_ready   = w_grant;
                    w_state_nxt = SETUP;
                end
            end
            SETUP:   w_state_nxt = ACCESS;
            ACCESS: begin
                if (pready || w_timeout) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // APB outputs, grant history and the response registers.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_paddr      <= '0;
            r_pwdata     <= '0;
            r_pwrite     <= 1'b0;
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_rsp_valid  <= '0;
            r_rsp_rdata  <= '0;
            r_rsp_err    <= 1'b0;
            r_last_grant <= PW'(NUM_REQ - 1);
        end else begin
            r_rsp_valid <= '0;
            case (r_state)
                IDLE: begin
                    if (|w_grant) begin
                        r_paddr      <= w_sel_addr;
                        r_pwrite     <= w_sel_write;
                        r_pwdata     <= w_sel_wdata;
                        r_psel       <= 1'b1;
                        r_penable    <= 1'b0;
                        r_last_grant <= w_sel_idx;
                    end
                end
                SETUP: r_penable <= 1'b1;
                ACCESS: begin
                    if (pready) begin
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= NUM_REQ'(1) << r_last_grant;
                        r_rsp_rdata <= r_pwrite ? '0 : prdata;
                        r_rsp_err   <= pslverr;
                    end else if (w_timeout) begin
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= NUM_REQ'(1) << r_last_grant;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign paddr     = r_paddr;
    assign pwdata    = r_pwdata;
    assign pwrite    = r_pwrite;
    assign psel      = r_psel;
    assign penable   = r_penable;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed self-checking bench for apb_master_arbiter (two requesters).
module tb_apb_master_arbiter;
    import apb_arb_pkg::*;

    localparam int unsigned NR = 2;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic             pclk = 1'b0;
    logic             presetn;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [NR-1:0]    req_write;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [NR-1:0]    rsp_valid;
    logic [DW-1:0]    rsp_rdata;
    logic             rsp_err;
    logic [AW-1:0]    paddr;
    logic             psel;
    logic             penable;
    logic             pwrite;
    logic [DW-1:0]    pwdata;
    logic [DW-1:0]    prdata;
    logic             pready;
    logic             pslverr;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    apb_master_arbiter #(
        .NUM_REQ        (NR),
        .APB_ADDR_WIDTH (AW),
        .APB_DATA_WIDTH (DW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .pclk      (pclk),
        .presetn   (presetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .paddr     (paddr),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic set_req(input int unsigned i, input apb_req_t c);
        req_write[i]           = c.write;
        req_addr[i*AW +: AW]   = c.addr;
        req_wdata[i*DW +: DW]  = c.wdata;
    endtask

    task automatic do_reset();
        presetn = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
        presetn = 1'b1;
    endtask

    initial begin
        logic [NR-1:0] exp_oh;
        presetn   = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        prdata    = '0;
        pready    = 1'b1;
        pslverr   = 1'b0;

        // Reset values
        repeat (2) @(posedge pclk);
        #1;
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_pwrite", pwrite, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        presetn = 1'b1;

        // Single zero-wait read by requester 0
        set_req(0, '{1'b0, 32'h0000_0010, 32'h0});
        prdata    = 32'hCAFE_F00D;
        req_valid = 2'b01;
        #1;
        chk("t1_ready", req_ready, 2'b01);
        tick();
        req_valid = '0;
        chk("t1_setup_psel", psel, 1);
        chk("t1_setup_penable", penable, 0);
        chk("t1_paddr", paddr, 32'h10);
        chk("t1_pwrite", pwrite, 0);
        chk("t1_ready_off", req_ready, 0);
        tick();
        chk("t1_access_psel", psel, 1);
        chk("t1_access_penable", penable, 1);
        tick();
        chk("t1_done_psel", psel, 0);
        chk("t1_done_penable", penable, 0);
        chk("t1_rsp_valid", rsp_valid, 2'b01);
        chk("t1_rsp_rdata", rsp_rdata, 32'hCAFE_F00D);
        chk("t1_rsp_err", rsp_err, 0);
        tick();
        chk("t1_rsp_pulse", rsp_valid, 0);

        // Round-robin writes, both requesters continuously valid
        do_reset();
        set_req(0, '{1'b1, 32'h0000_0004, 32'hA0A0_0000});
        set_req(1, '{1'b1, 32'h0000_0008, 32'hB1B1_1111});
        req_valid = 2'b11;
        #1;
        for (int t = 0; t < 6; t++) begin
            exp_oh = (t % 2 == 0) ? 2'b01 : 2'b10;
            chk("t2_ready", req_ready, exp_oh);
            tick();
            chk("t2_paddr", paddr, (t % 2 == 0) ? 32'h4 : 32'h8);
            chk("t2_pwdata", pwdata, (t % 2 == 0) ? 32'hA0A0_0000 : 32'hB1B1_1111);
            chk("t2_pwrite", pwrite, 1);
            chk("t2_setup", {psel, penable}, 2'b10);
            tick();
            chk("t2_access", {psel, penable}, 2'b11);
            tick();
            chk("t2_rsp_valid", rsp_valid, exp_oh);
        end
        req_valid = '0;
        tick();
        chk("t2_idle_psel", psel, 0);

        // Four wait states on a read by requester 0
        set_req(0, '{1'b0, 32'h0000_0020, 32'h0});
        prdata    = 32'h1234_5678;
        pready    = 1'b0;
        req_valid = 2'b01;
        #1;
        chk("t3_ready", req_ready, 2'b01);
        tick();
        req_valid = '0;
        chk("t3_setup", {psel, penable}, 2'b10);
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("t3_hold_paddr", paddr, 32'h20);
            chk("t3_hold_pwdata", pwdata, 32'h0);
            chk("t3_hold_pwrite", pwrite, 0);
            chk("t3_hold_sel_en", {psel, penable}, 2'b11);
            chk("t3_no_rsp", rsp_valid, 0);
            if (k == 4) pready = 1'b1;
            tick();
        end
        chk("t3_rsp_valid", rsp_valid, 2'b01);
        chk("t3_rsp_rdata", rsp_rdata, 32'h1234_5678);
        chk("t3_psel_off", psel, 0);
        tick();
        chk("t3_rsp_pulse", rsp_valid, 0);

        // Slave error on a write, then a clean read
        set_req(1, '{1'b1, 32'h0000_FFFC, 32'hDEAD_BEEF});
        pslverr   = 1'b1;
        req_valid = 2'b10;
        #1;
        chk("t4_ready", req_ready, 2'b10);
        tick();
        req_valid = '0;
        tick();
        tick();
        chk("t4_rsp_valid", rsp_valid, 2'b10);
        chk("t4_rsp_err", rsp_err, 1);
        chk("t4_rsp_rdata", rsp_rdata, 32'h0);
        pslverr = 1'b0;
        set_req(0, '{1'b0, 32'h0000_0030, 32'h0});
        prdata    = 32'h55AA_55AA;
        req_valid = 2'b01;
        #1;
        chk("t4b_ready", req_ready, 2'b01);
        tick();
        req_valid = '0;
        tick();
        tick();
        chk("t4b_rsp_valid", rsp_valid, 2'b01);
        chk("t4b_rsp_err", rsp_err, 0);
        chk("t4b_rsp_rdata", rsp_rdata, 32'h55AA_55AA);

        // Reset during ACCESS
        set_req(1, '{1'b1, 32'h0000_0040, 32'h0BAD_0BAD});
        set_req(0, '{1'b0, 32'h0000_0044, 32'h0});
        pready    = 1'b0;
        req_valid = 2'b11;
        #1;
        chk("t5_ready", req_ready, 2'b10);
        tick();
        req_valid = '0;
        tick();
        chk("t5_access", {psel, penable}, 2'b11);
        #2;
        presetn = 1'b0;
        #1;
        chk("t5_async_drop", {psel, penable}, 2'b00);
        @(posedge pclk);
        #1;
        chk("t5_no_rsp", rsp_valid, 0);
        presetn   = 1'b1;
        pready    = 1'b1;
        req_valid = 2'b11;
        #1;
        chk("t5_first_grant", req_ready, 2'b01);
        tick();
        req_valid = '0;
        chk("t5_paddr", paddr, 32'h44);
        tick();
        tick();
        chk("t5_rsp_valid", rsp_valid, 2'b01);

        // Stalled slave: abort with the timeout feature, wait without it
        set_req(1, '{1'b0, 32'h0000_0050, 32'h0});
        prdata    = 32'hFFFF_FFFF;
        pready    = 1'b0;
        req_valid = 2'b10;
        #1;
        chk("t6_ready", req_ready, 2'b10);
        tick();
        req_valid = '0;
        tick();
`ifdef APB_ARB_TIMEOUT_EN
        for (int k = 0; k < 8; k++) begin
            chk("t6_wait_psel", psel, 1);
            chk("t6_wait_no_rsp", rsp_valid, 0);
            tick();
        end
        chk("t6_abort_sel_en", {psel, penable}, 2'b00);
        chk("t6_abort_rsp_valid", rsp_valid, 2'b10);
        chk("t6_abort_err", rsp_err, 1);
        chk("t6_abort_rdata", rsp_rdata, 32'h0);
        pready = 1'b1;
        tick();
        chk("t6_idle_rsp", rsp_valid, 0);
        chk("t6_idle_psel", psel, 0);
`else
        for (int k = 0; k < 20; k++) begin
            chk("t6_wait_sel_en", {psel, penable}, 2'b11);
            chk("t6_wait_no_rsp", rsp_valid, 0);
            if (k == 19) pready = 1'b1;
            tick();
        end
        chk("t6_rsp_valid", rsp_valid, 2'b10);
        chk("t6_rsp_err", rsp_err, 0);
        chk("t6_rsp_rdata", rsp_rdata, 32'hFFFF_FFFF);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- Shares one APB master port between NUM_REQ on-chip requesters, e.g. the I2S DMA/control engines and a debug/config sequencer.
- Picks one requester per transfer by round-robin and captures its command.
- Drives the APB SETUP/ACCESS sequence, waits for pready, then returns read data and error status to the granted requester.

Parameters:
- NUM_REQ, 2, number of requester ports (2..8).
- APB_ADDR_WIDTH, 32, APB address width.
- APB_DATA_WIDTH, 32, APB data width.
- TIMEOUT_CYCLES, 256, maximum ACCESS cycles before abort (used only with the optional feature).

Ports:
- pclk  in  1  clock.
- presetn  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_ready  out  NUM_REQ  one-hot accept pulse.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*APB_ADDR_WIDTH  packed addresses; requester i uses slice i.
- req_wdata  in  NUM_REQ*APB_DATA_WIDTH  packed write data.
- rsp_valid  out  NUM_REQ  one-hot completion pulse.
- rsp_rdata  out  APB_DATA_WIDTH  read data, valid with rsp_valid.
- rsp_err  out  1  pslverr or timeout, valid with rsp_valid.
- paddr  out  APB_ADDR_WIDTH  APB address.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- pwdata  out  APB_DATA_WIDTH  APB write data.
- prdata  in  APB_DATA_WIDTH  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB slave error.

Behaviour:
- Reset state, all registered: state=IDLE; psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err all 0. Round-robin pointer set so requester 0 has top priority.
- Reset is asynchronous. Asserting it mid-transfer drops psel/penable immediately. The transfer is lost and no rsp_valid is produced.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - If any req_valid is set, grant g = first set bit searching upward (with wrap) from (last_grant+1) mod NUM_REQ.
  - In the same cycle, req_ready[g]=1 (combinational, one cycle); req_ready is 0 in all other states.
  - On the next edge: latch addr/write/wdata of g into paddr/pwrite/pwdata, psel=1, penable=0, last_grant=g, go to SETUP.
- SETUP: exactly one cycle; next edge sets penable=1 and goes to ACCESS.
- ACCESS:
  - Hold all APB outputs stable while pready=0.
  - On a cycle with pready=1: next edge sets psel=0, penable=0, rsp_valid[g]=1, rsp_rdata=prdata (reads only, else 0), rsp_err=pslverr, and returns to IDLE.
- rsp_valid lasts one cycle. A new grant may occur in that same IDLE cycle, giving back-to-back transfers of 3 cycles each with zero-wait slaves.
- paddr/pwrite/pwdata hold their last values while idle.
- req_valid may drop before acceptance without effect. A command is committed only when req_ready is seen.
- A requester that is not granted stays pending. With all requesters continuously valid, grants rotate 0,1,…,NUM_REQ-1,0.
- All grant and response vectors are one-hot or zero.

Optional Feature:
- Macro: APB_ARB_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) clears on entering ACCESS and increments each ACCESS cycle with pready=0.
  - When it reaches TIMEOUT_CYCLES with pready still 0: abort, giving psel=0, penable=0, rsp_valid[g]=1, rsp_err=1, rsp_rdata=0, and return to IDLE.
  - pready in that same cycle takes precedence over the timeout.
- Not defined: no counter; ACCESS waits indefinitely.

Decomposition:
- Package apb_arb_pkg holds:
  - the state enum (IDLE, SETUP, ACCESS);
  - the request struct (write, addr, wdata);
  - localparam for the default timeout.
- Sub-module rr_arbiter (parameter N): inputs req vector, pointer and enable; output one-hot grant. Purely combinational, instantiated once.

Test Plan:
- Single read, requester 0, addr 0x0000_0010, zero-wait slave returning 0xCAFE_F00D → psel high 2 cycles and penable 1 cycle; rsp_valid=01 three cycles after req_ready with rsp_rdata=0xCAFE_F00D, rsp_err=0.
- Both requesters continuously valid, 6 writes, addr 0x04/0x08 → grant order 0,1,0,1,0,1; pwdata matches the granted requester; 3 cycles per transfer.
- Slave inserts 4 wait states → paddr/pwdata/pwrite/psel/penable stable for 5 ACCESS cycles; single rsp_valid pulse.
- pslverr=1 with pready on write to 0xFFFC → rsp_err=1 with rsp_valid; next transfer has rsp_err=0.
- presetn asserted during ACCESS → psel/penable 0 immediately, no rsp_valid; after release, requester 0 wins the first grant.
- With APB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, pready held 0 → abort after 8 ACCESS cycles with rsp_err=1, rsp_rdata=0, FSM back to IDLE.
